// File: rtl/tblc_pipe_if.sv
// Valid/ready stream bundle for the truncated binary-log converter:
// operand side (in_*) and result side (out_*), seen from the producer/consumer (master) and the converter (slave).
interface tblc_pipe_if #(
  parameter int W    = 16,
  parameter int M    = 5,
  parameter int TAGW = 1
) ();
  localparam int KW = $clog2(W);

  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_x;
  logic [TAGW-1:0]   in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [KW+W-M-1:0] out_tlog;
  logic              out_zero;
  logic [TAGW-1:0]   out_tag;

  modport master (
    output in_valid, in_x, in_tag, out_ready,
    input  in_ready, out_valid, out_tlog, out_zero, out_tag
  );

  modport slave (
    input  in_valid, in_x, in_tag, out_ready,
    output in_ready, out_valid, out_tlog, out_zero, out_tag
  );
endinterface

// File: rtl/tblc_pipe.sv
// Two-stage truncated binary-log converter: S1 finds the leading one, S2 aligns the mantissa,
// optionally rounds it and registers {k, y}. Valid/ready on both sides with a combinational stall chain.
module tblc_pipe #(
  parameter int W    = 16,
  parameter int M    = 5,
  parameter int RND  = 0,
  parameter int TAGW = 1
) (
  input logic        clk,
  input logic        rst,
  tblc_pipe_if.slave bus
);
  localparam int KW = $clog2(W);
  localparam int FW = W - M;

  logic            s1_valid;
  logic            s2_valid;
  logic            s1_adv;
  logic            s2_adv;
  logic [W-1:0]    s1_x;
  logic [TAGW-1:0] s1_tag;
  logic [KW-1:0]   s1_k;
  logic            s1_zero;

  logic [KW-1:0]   lo_k;
  logic            lo_zero;
  logic [W-1:0]    s_al;
  logic [FW-1:0]   y_tr;
  logic [FW-1:0]   y_rnd;
  logic            unused_s;

  assign s2_adv        = !s2_valid || bus.out_ready;
  assign s1_adv        = !s1_valid || s2_adv;
  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid;

  // Highest set bit wins: later iterations overwrite lower positions.
  always_comb begin
    lo_k = '0;
    for (int i = 0; i < W; i++) begin
      if (bus.in_x[i]) lo_k = KW'(i);
    end
    lo_zero = (bus.in_x == '0);
  end

  // Left-align so the leading one sits in the MSB; the bits below it form the mantissa.
  always_comb begin
    s_al  = s1_x << (KW'(W - 1) - s1_k);
    y_tr  = s_al[W-2:M-1];
    y_rnd = y_tr;
    if (RND != 0 && s_al[M-2] && !(&y_tr)) y_rnd = y_tr + FW'(1);
  end

  assign unused_s = ^{s_al[W-1], s_al[M-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      s1_x         <= '0;
      s1_tag       <= '0;
      s1_k         <= '0;
      s1_zero      <= 1'b0;
      bus.out_tlog <= '0;
      bus.out_zero <= 1'b0;
      bus.out_tag  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_x    <= bus.in_x;
          s1_tag  <= bus.in_tag;
          s1_k    <= lo_k;
          s1_zero <= lo_zero;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_tlog <= {s1_k, y_rnd};
          bus.out_zero <= s1_zero;
          bus.out_tag  <= s1_tag;
        end
      end
    end
  end
endmodule

// File: tb/tb_tblc_pipe.sv
// Directed and randomized bench for tblc_pipe: b0 drives a truncating instance, b1 a rounding one.
module tb_tblc_pipe;
  localparam int W    = 16;
  localparam int M    = 5;
  localparam int TAGW = 1;
  localparam int KW   = $clog2(W);
  localparam int FW   = W - M;
  localparam int TW   = KW + FW;

  typedef logic [TW+TAGW:0] ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;
  ent_t sb[$];

  always #5 clk = ~clk;

  tblc_pipe_if #(.W(W), .M(M), .TAGW(TAGW)) b0 ();
  tblc_pipe_if #(.W(W), .M(M), .TAGW(TAGW)) b1 ();

  tblc_pipe #(.W(W), .M(M), .RND(0), .TAGW(TAGW)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  tblc_pipe #(.W(W), .M(M), .RND(1), .TAGW(TAGW)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  // Reference: walks bits below the leading one directly, no shifter.
  function automatic logic [TW:0] model(input logic [W-1:0] x, input bit rnd);
    int k = -1;
    int pos;
    logic [FW-1:0] y = '0;
    for (int i = W - 1; i >= 0; i--) if (x[i] && k < 0) k = i;
    if (k < 0) return {{TW{1'b0}}, 1'b1};
    for (int j = 0; j < FW; j++) begin
      pos = k - 1 - j;
      if (pos >= 0) y[FW-1-j] = x[pos];
    end
    pos = k - 1 - FW;
    if (rnd && pos >= 0 && x[pos] && !(&y)) y = y + 1'b1;
    return {KW'(k), y, 1'b0};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    b0.in_valid = 1'b1; b0.in_x = 16'hABCD; b0.in_tag = 1'b1; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_x = '0; b1.in_tag = 1'b0; b1.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({b0.out_valid, b0.out_tlog, b0.out_zero, b0.out_tag} !== '0)
      $display("FAIL reset_state: got v=%b tlog=%h z=%b tag=%b want all zero",
               b0.out_valid, b0.out_tlog, b0.out_zero, b0.out_tag);
    else passed++;
    @(negedge clk);
    rst = 1'b0; b0.in_valid = 1'b0;
    #1;
    checks++;
    if (b0.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", b0.in_ready);
    else passed++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++;
      if (b0.out_valid !== 1'b0) $display("FAIL reset_no_accept c%0d: out_valid %b want 0", c, b0.out_valid);
      else passed++;
    end
  endtask

  task automatic test_directed();
    logic [15:0] xs [6];
    logic [14:0] et [6];
    logic        ez [6];
    xs = '{16'h8000, 16'hC000, 16'h0003, 16'h0000, 16'h8018, 16'h0001};
    et = '{15'h7800, 15'h7C00, 15'h0C00, 15'h0000, 15'h7801, 15'h0000};
    ez = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      b0.in_valid = 1'b1; b0.in_x = xs[i]; b0.in_tag = i[0];
      #1;
      checks++;
      if (b0.in_ready !== 1'b1) $display("FAIL directed_in_ready %0d: got %b want 1", i, b0.in_ready);
      else passed++;
      @(negedge clk);
      b0.in_valid = 1'b0;
      #1;
      checks++;
      if (b0.out_valid !== 1'b0) $display("FAIL directed_early %0d: out_valid %b want 0", i, b0.out_valid);
      else passed++;
      @(negedge clk); #1;
      checks++;
      if ({b0.out_valid, b0.out_tlog, b0.out_zero, b0.out_tag} !== {1'b1, et[i], ez[i], i[0]})
        $display("FAIL directed %h: got v=%b tlog=%h z=%b tag=%b want v=1 tlog=%h z=%b tag=%b",
                 xs[i], b0.out_valid, b0.out_tlog, b0.out_zero, b0.out_tag, et[i], ez[i], i[0]);
      else passed++;
    end
  endtask

  task automatic test_round();
    logic [15:0] xs [5];
    logic [14:0] et [5];
    logic        ez [5];
    xs = '{16'h8018, 16'hFFFF, 16'h800F, 16'h0000, 16'h0018};
    et = '{15'h7802, 15'h7FFF, 15'h7801, 15'h0000, 15'h2400};
    ez = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b1.in_valid = 1'b1; b1.in_x = xs[i]; b1.in_tag = i[0];
      @(negedge clk);
      b1.in_valid = 1'b0;
      @(negedge clk); #1;
      checks++;
      if ({b1.out_valid, b1.out_tlog, b1.out_zero, b1.out_tag} !== {1'b1, et[i], ez[i], i[0]})
        $display("FAIL round %h: got v=%b tlog=%h z=%b tag=%b want v=1 tlog=%h z=%b tag=%b",
                 xs[i], b1.out_valid, b1.out_tlog, b1.out_zero, b1.out_tag, et[i], ez[i], i[0]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, got = 0, first = -1, last = -1, errs = 0;
    ent_t e;
    sb.delete();
    for (int c = 0; c < 200 && got < 64; c++) begin
      @(negedge clk);
      b0.out_ready = 1'b1;
      b0.in_valid  = (sent < 64);
      b0.in_x      = 16'($urandom >> $urandom_range(0, 20));
      b0.in_tag    = 1'($urandom);
      #1;
      if (b0.in_valid && b0.in_ready) begin
        sb.push_back({model(b0.in_x, 1'b0), b0.in_tag});
        sent++;
      end else if (b0.in_valid) errs++;
      if (b0.out_valid && b0.out_ready) begin
        e = sb.pop_front();
        checks++;
        if ({b0.out_tlog, b0.out_zero, b0.out_tag} !== e)
          $display("FAIL b2b result %0d: got %h want %h", got, {b0.out_tlog, b0.out_zero, b0.out_tag}, e);
        else passed++;
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    checks++;
    if (got != 64 || last - first != 63 || errs != 0)
      $display("FAIL b2b_rate: got %0d results over %0d cycles, %0d refusals; want 64 over 64, 0", got, last - first + 1, errs);
    else passed++;
    @(negedge clk); b0.in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic [15:0] xs [4];
    logic [14:0] et [4];
    logic        ez [4];
    logic        er [5];
    int idx = 0, got = 0;
    xs = '{16'h1234, 16'h0040, 16'hFFFF, 16'h0000};
    et = '{15'h611A, 15'h3000, 15'h7FFF, 15'h0000};
    ez = '{1'b0, 1'b0, 1'b0, 1'b1};
    er = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      b0.out_ready = (c >= 5);
      b0.in_valid  = (idx < 4);
      b0.in_x      = xs[idx & 3];
      b0.in_tag    = idx[0];
      #1;
      if (c < 5) begin
        checks++;
        if (b0.in_ready !== er[c]) $display("FAIL stall_in_ready c%0d: got %b want %b", c, b0.in_ready, er[c]);
        else passed++;
      end
      if (c >= 2 && c < 5) begin
        checks++;
        if ({b0.out_valid, b0.out_tlog} !== {1'b1, et[0]})
          $display("FAIL stall_hold c%0d: got v=%b tlog=%h want v=1 tlog=%h", c, b0.out_valid, b0.out_tlog, et[0]);
        else passed++;
      end
      if (b0.in_valid && b0.in_ready) idx++;
      if (b0.out_valid && b0.out_ready) begin
        checks++;
        if ({b0.out_tlog, b0.out_zero, b0.out_tag} !== {et[got & 3], ez[got & 3], got[0]})
          $display("FAIL stall_drain %0d: got tlog=%h z=%b tag=%b want tlog=%h z=%b tag=%b",
                   got, b0.out_tlog, b0.out_zero, b0.out_tag, et[got & 3], ez[got & 3], got[0]);
        else passed++;
        got++;
      end
    end
    checks++;
    if (got != 4) $display("FAIL stall_count: got %0d results want 4", got);
    else passed++;
  endtask

  task automatic test_random();
    int sent = 0, got = 0, bad = 0, held = 0;
    bit prev_stall = 1'b0;
    ent_t e, prev;
    sb.delete();
    for (int c = 0; c < 60000 && got < 10000; c++) begin
      @(negedge clk);
      b0.in_valid  = (sent < 10000) && ($urandom_range(0, 1) == 1);
      b0.in_x      = 16'($urandom >> $urandom_range(0, 31));
      b0.in_tag    = 1'($urandom);
      b0.out_ready = ($urandom_range(0, 1) == 1);
      #1;
      if (prev_stall) begin
        checks++;
        if ({b0.out_valid, b0.out_tlog, b0.out_zero, b0.out_tag} !== {1'b1, prev}) begin
          held++;
          if (held < 5) $display("FAIL random_hold c%0d: got v=%b %h want v=1 %h", c, b0.out_valid,
                                 {b0.out_tlog, b0.out_zero, b0.out_tag}, prev);
        end else passed++;
      end
      prev_stall = b0.out_valid && !b0.out_ready;
      prev = {b0.out_tlog, b0.out_zero, b0.out_tag};
      if (b0.in_valid && b0.in_ready) begin
        sb.push_back({model(b0.in_x, 1'b0), b0.in_tag});
        sent++;
      end
      if (b0.out_valid && b0.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          bad++;
          if (bad < 5) $display("FAIL random_extra %0d: result with empty scoreboard", got);
        end else begin
          e = sb.pop_front();
          if ({b0.out_tlog, b0.out_zero, b0.out_tag} !== e) begin
            bad++;
            if (bad < 5) $display("FAIL random_result %0d: got %h want %h", got,
                                  {b0.out_tlog, b0.out_zero, b0.out_tag}, e);
          end else passed++;
        end
        got++;
      end
    end
    checks++;
    if (got != 10000 || sb.size() != 0)
      $display("FAIL random_count: got %0d results, %0d pending want 10000, 0", got, sb.size());
    else passed++;
    @(negedge clk); b0.in_valid = 1'b0; b0.out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight();
    bit seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      b0.out_ready = 1'b0; b0.in_valid = 1'b1; b0.in_x = 16'h8000 >> c; b0.in_tag = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1; b0.in_x = 16'hC000;
    #1;
    checks++;
    if ({b0.out_valid, b0.in_ready} !== 2'b10)
      $display("FAIL midreset_full: got v=%b rdy=%b want v=1 rdy=0", b0.out_valid, b0.in_ready);
    else passed++;
    @(negedge clk);
    rst = 1'b0; b0.in_valid = 1'b0; b0.out_ready = 1'b1;
    #1;
    checks++;
    if ({b0.out_valid, b0.in_ready} !== 2'b01)
      $display("FAIL midreset_after: got v=%b rdy=%b want v=0 rdy=1", b0.out_valid, b0.in_ready);
    else passed++;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (b0.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) $display("FAIL midreset_stale: got stale out_valid=1 want 0");
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_round();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
